// File: rtl/sample_round_scheduler.sv
// sample_round_scheduler: round-robin arbiter that shares one sample-burst
// sequencer among NUM_REQ requesters. Each grant emits numbered sample strobes
// for the winner, pulses that requester's done, then enforces an idle gap.
module sample_round_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int OWNER_W    = 2,
  parameter int SAMPLE_W   = 16,
  parameter int MAX_LEN    = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*SAMPLE_W-1:0]   burst_len,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          sample_valid,
  output logic [SAMPLE_W-1:0]           sample_index,
  output logic [OWNER_W-1:0]            sample_owner,
  output logic [NUM_REQ-1:0]            done,
  output logic [31:0]                   burst_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // The gap counter holds GAP_CYCLES-1 down to 0, so it never needs more bits
  // than it takes to represent GAP_CYCLES-1.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [SAMPLE_W-1:0] MAX_LEN_S = SAMPLE_W'(MAX_LEN);
  localparam logic [GAP_W-1:0]    GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t               state_q, state_n;
  logic [OWNER_W-1:0]   ptr_q, ptr_n;
  logic [SAMPLE_W-1:0]  len_q, len_n;
  logic [GAP_W-1:0]     gap_q, gap_n;

  logic [NUM_REQ-1:0]   grant_n;
  logic                 busy_n;
  logic                 sample_valid_n;
  logic [SAMPLE_W-1:0]  sample_index_n;
  logic [OWNER_W-1:0]   sample_owner_n;
  logic [NUM_REQ-1:0]   done_n;
  logic [31:0]          burst_count_n;

  logic                 win_found;
  logic [OWNER_W-1:0]   win_idx;
  logic [SAMPLE_W-1:0]  win_len_raw;
  logic [SAMPLE_W-1:0]  win_len;
  logic [OWNER_W-1:0]   win_next_ptr;
  logic                 last_cycle;

  // Rotating priority search: the first asserted req at or after ptr_q wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req[(int'(ptr_q) + i) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = OWNER_W'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  // Winner's burst length (clamped) and the rotated pointer for the next round.
  always_comb begin
    win_len_raw  = burst_len[int'(win_idx)*SAMPLE_W +: SAMPLE_W];
    win_len      = (win_len_raw > MAX_LEN_S) ? MAX_LEN_S : win_len_raw;
    win_next_ptr = (win_idx == OWNER_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    // A zero-length burst still occupies one RUN cycle, then completes.
    last_cycle   = (len_q == '0) || (sample_index == len_q - 1'b1);
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n        = state_q;
    ptr_n          = ptr_q;
    len_n          = len_q;
    gap_n          = gap_q;
    grant_n        = grant;
    sample_valid_n = sample_valid;
    sample_index_n = sample_index;
    sample_owner_n = sample_owner;
    done_n         = '0;
    burst_count_n  = burst_count;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_n        = RUN;
          ptr_n          = win_next_ptr;
          len_n          = win_len;
          grant_n        = NUM_REQ'(1) << win_idx;
          sample_owner_n = win_idx;
          sample_index_n = '0;
          sample_valid_n = (win_len != '0);
        end
      end
      RUN: begin
        if (last_cycle) begin
          grant_n        = '0;
          sample_valid_n = 1'b0;
          sample_index_n = '0;
          done_n         = grant;
          burst_count_n  = burst_count + 32'd1;
          gap_n          = GAP_LOAD;
          state_n        = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          sample_index_n = sample_index + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_n = IDLE;
        end else begin
          gap_n = gap_q - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (grant_n != '0) || (state_n == GAP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the same pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      len_q        <= '0;
      gap_q        <= '0;
      grant        <= '0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_index <= '0;
      sample_owner <= '0;
      done         <= '0;
      burst_count  <= '0;
    end else begin
      state_q      <= state_n;
      ptr_q        <= ptr_n;
      len_q        <= len_n;
      gap_q        <= gap_n;
      grant        <= grant_n;
      busy         <= busy_n;
      sample_valid <= sample_valid_n;
      sample_index <= sample_index_n;
      sample_owner <= sample_owner_n;
      done         <= done_n;
      burst_count  <= burst_count_n;
    end
  end

endmodule

// File: tb/tb_sample_round_scheduler.sv
// Testbench for sample_round_scheduler: directed bursts with a scoreboard of
// expected (owner, index) strobes and done pulses, checked by a monitor, plus
// a second instance with GAP_CYCLES=0 for back-to-back timing.
module tb_sample_round_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] burst_len;
  logic [3:0]  grant;
  logic        busy;
  logic        sample_valid;
  logic [15:0] sample_index;
  logic [1:0]  sample_owner;
  logic [3:0]  done;
  logic [31:0] burst_count;

  logic        b_reset;
  logic [3:0]  b_req;
  logic [63:0] b_burst_len;
  logic [3:0]  b_grant;
  logic        b_busy;
  logic        b_sample_valid;
  logic [15:0] b_sample_index;
  logic [1:0]  b_sample_owner;
  logic [3:0]  b_done;
  logic [31:0] b_burst_count;

  typedef struct packed {
    logic [1:0]  owner;
    logic [15:0] index;
  } sample_t;

  sample_t sb_q[$];
  int      done_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;

  sample_round_scheduler #(
    .NUM_REQ(4), .OWNER_W(2), .SAMPLE_W(16), .MAX_LEN(64), .GAP_CYCLES(2)
  ) u_dut (
    .clk(clk), .reset(reset), .req(req), .burst_len(burst_len),
    .grant(grant), .busy(busy), .sample_valid(sample_valid),
    .sample_index(sample_index), .sample_owner(sample_owner),
    .done(done), .burst_count(burst_count)
  );

  sample_round_scheduler #(
    .NUM_REQ(4), .OWNER_W(2), .SAMPLE_W(16), .MAX_LEN(64), .GAP_CYCLES(0)
  ) u_dut_nogap (
    .clk(clk), .reset(b_reset), .req(b_req), .burst_len(b_burst_len),
    .grant(b_grant), .busy(b_busy), .sample_valid(b_sample_valid),
    .sample_index(b_sample_index), .sample_owner(b_sample_owner),
    .done(b_done), .burst_count(b_burst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_len(input int k, input int v);
    burst_len[k*16 +: 16] = 16'(v);
  endtask

  // Expected strobes for a burst (clamped to 64) and its done pulse.
  task automatic push_burst(input int owner, input int len);
    int n;
    n = (len > 64) ? 64 : len;
    for (int i = 0; i < n; i++) sb_q.push_back({2'(owner), 16'(i)});
    done_q.push_back(owner);
  endtask

  task automatic wait_grant(input int owner, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (grant[owner] === 1'b1) seen = 1'b1;
    end
    check($sformatf("grant_seen_%0d", owner), 32'(seen), 32'd1);
  endtask

  task automatic drain(input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && done_q.size() == 0 && busy === 1'b0) ok = 1'b1;
    end
    check("drain", 32'(ok), 32'd1);
  endtask

  // Monitor: every strobe and done pulse must match the head of its queue.
  always @(negedge clk) begin
    logic    have;
    sample_t exp_s;
    int      exp_d;
    if (sample_valid === 1'b1) begin
      have = (sb_q.size() != 0);
      check("sample_expected", 32'(have), 32'd1);
      if (have) begin
        exp_s = sb_q.pop_front();
        check("sample_owner", 32'(sample_owner), 32'(exp_s.owner));
        check("sample_index", 32'(sample_index), 32'(exp_s.index));
      end
      check("grant_matches_owner", 32'(grant), 32'(4'b0001 << sample_owner));
    end
    if (|done === 1'b1) begin
      have = (done_q.size() != 0);
      check("done_expected", 32'(have), 32'd1);
      if (have) begin
        exp_d = done_q.pop_front();
        check("done_onehot", 32'(done), 32'(4'b0001 << exp_d));
      end
    end
  end

  initial begin
    logic seen;
    int   nd;

    reset = 1'b1; req = '0; burst_len = '0;
    b_reset = 1'b1; b_req = '0; b_burst_len = '0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_index", 32'(sample_index), 32'd0);
    check("rst_owner", 32'(sample_owner), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", burst_count, 32'd0);
    reset = 1'b0;

    // Single request, len=5, then gap timing into a zero-length burst.
    set_len(0, 5);
    req = 4'b0001;
    push_burst(0, 5);
    wait_grant(0, 10);
    check("single_grant", 32'(grant), 32'h1);
    check("single_busy", 32'(busy), 32'd1);
    req = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done[0] === 1'b1) seen = 1'b1;
    end
    check("single_done_seen", 32'(seen), 32'd1);
    check("single_count", burst_count, 32'd1);
    check("single_grant_dropped", 32'(grant), 32'd0);
    check("gap_busy_n0", 32'(busy), 32'd1);
    set_len(0, 0);
    req = 4'b0001;
    push_burst(0, 0);
    @(negedge clk);
    check("gap_busy_n1", 32'(busy), 32'd1);
    check("gap_grant_n1", 32'(grant), 32'd0);
    @(negedge clk);
    check("gap_busy_n2", 32'(busy), 32'd0);
    check("gap_grant_n2", 32'(grant), 32'd0);
    @(negedge clk);
    check("zero_grant_n3", 32'(grant), 32'h1);
    check("zero_valid_n3", 32'(sample_valid), 32'd0);
    req = 4'b0000;
    @(negedge clk);
    check("zero_grant_n4", 32'(grant), 32'd0);
    check("zero_done_n4", 32'(done), 32'h1);
    drain(20);
    check("zero_count", burst_count, 32'd2);

    // Clamp: 100 requested, 64 strobes issued.
    set_len(3, 100);
    req = 4'b1000;
    push_burst(3, 100);
    wait_grant(3, 10);
    req = 4'b0000;
    drain(200);
    check("clamp_count", burst_count, 32'd3);

    // Request drop and late length change: original 8 strobes still issued.
    set_len(2, 8);
    req = 4'b0100;
    push_burst(2, 8);
    wait_grant(2, 10);
    req = 4'b0000;
    set_len(2, 20);
    drain(60);
    check("drop_count", burst_count, 32'd4);

    // Reset mid-burst at sample_index 3 of a 10-sample burst.
    set_len(1, 10);
    req = 4'b0010;
    for (int i = 0; i < 4; i++) sb_q.push_back({2'd1, 16'(i)});
    wait_grant(1, 10);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (sample_index === 16'd3 && sample_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    check("midburst_index3_seen", 32'(seen), 32'd1);
    reset = 1'b1;
    req = 4'b0110;
    @(negedge clk);
    check("mrst_grant", 32'(grant), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_valid", 32'(sample_valid), 32'd0);
    check("mrst_index", 32'(sample_index), 32'd0);
    check("mrst_owner", 32'(sample_owner), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_count", burst_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    push_burst(1, 10);
    wait_grant(1, 10);
    check("post_rst_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    drain(40);
    check("post_rst_count", burst_count, 32'd1);

    // Round robin from a fresh reset: order 0,1,2,3,0 with 3 strobes each.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) set_len(k, 3);
    req = 4'b1111;
    push_burst(0, 3); push_burst(1, 3); push_burst(2, 3); push_burst(3, 3); push_burst(0, 3);
    nd = 0;
    for (int i = 0; i < 100 && nd < 4; i++) begin
      @(negedge clk);
      if (|done === 1'b1) nd++;
    end
    check("rr_four_dones", 32'(nd), 32'd4);
    wait_grant(0, 10);
    req = 4'b0000;
    drain(40);
    check("rr_count", burst_count, 32'd5);

    // GAP_CYCLES=0 instance: back-to-back req=0011, len=2.
    b_burst_len[0 +: 16]  = 16'd2;
    b_burst_len[16 +: 16] = 16'd2;
    @(negedge clk);
    b_reset = 1'b0;
    b_req = 4'b0011;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (b_done[0] === 1'b1) seen = 1'b1;
    end
    check("nogap_done0_seen", 32'(seen), 32'd1);
    check("nogap_busy_idle", 32'(b_busy), 32'd0);
    check("nogap_grant_idle", 32'(b_grant), 32'd0);
    check("nogap_count1", b_burst_count, 32'd1);
    @(negedge clk);
    check("nogap_grant1", 32'(b_grant), 32'h2);
    check("nogap_busy1", 32'(b_busy), 32'd1);
    check("nogap_index1", 32'(b_sample_index), 32'd0);
    b_req = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (b_done[1] === 1'b1) seen = 1'b1;
    end
    check("nogap_done1_seen", 32'(seen), 32'd1);
    check("nogap_count2", b_burst_count, 32'd2);
    @(negedge clk);
    check("nogap_busy_end", 32'(b_busy), 32'd0);

    check("sb_samples_left", 32'(sb_q.size()), 32'd0);
    check("sb_dones_left", 32'(done_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_round_scheduler.md
# sample_round_scheduler

Round-robin scheduler that shares a single sample-burst datapath among several requesters in the decoder test/measurement infrastructure. Each requester raises a level request with its own burst length. The block grants one requester at a time and emits that requester's numbered sample strobes. It then signals completion to that requester and enforces an idle gap before the next grant. It replaces the per-channel fixed-64 burst generation with a single configurable, arbitrated sequencer.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- OWNER_W, 2, width of owner index, must equal ceil(log2(NUM_REQ))
- SAMPLE_W, 16, width of burst length and sample index
- MAX_LEN, 64, maximum burst length; larger requests are clamped to this value
- GAP_CYCLES, 2, idle cycles inserted after each burst (0 allowed)
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  NUM_REQ  level request per requester
- burst_len  input  NUM_REQ*SAMPLE_W  per-requester burst length; slot i is [i*SAMPLE_W +: SAMPLE_W]
- grant  output  NUM_REQ  one-hot grant, held for the whole burst
- busy  output  1  high while any grant is active or the gap is running
- sample_valid  output  1  one strobe per sample
- sample_index  output  SAMPLE_W  index of the current sample, 0..len-1
- sample_owner  output  OWNER_W  index of the granted requester
- done  output  NUM_REQ  one-cycle completion pulse to the owner
- burst_count  output  32  total completed bursts, wraps at 2^32

## Operation
- States:
  - IDLE: arbitrate among the asserted req bits.
  - RUN: emit samples for the granted requester.
  - GAP: count down GAP_CYCLES before returning to IDLE.
- All outputs are registered. Reset values: grant=0, busy=0, sample_valid=0, sample_index=0, sample_owner=0, done=0, burst_count=0, state=IDLE, rr pointer=0.
- Arbitration: search starts at pointer p and wraps modulo NUM_REQ; the first asserted req wins. After a grant to requester k, p = (k+1) mod NUM_REQ. After reset, requester 0 has highest priority.
- At grant: latch len = min(burst_len slot k, MAX_LEN); set sample_owner=k.
- RUN:
  - sample_valid=1 each cycle with sample_index = 0,1,…,len-1.
  - On the cycle after the last sample: drop grant and sample_valid, pulse done[k], increment burst_count, set sample_index=0. Go to GAP, or to IDLE if GAP_CYCLES=0.
- len=0: grant is held for exactly 1 cycle with sample_valid=0, then done is pulsed as above.
- Requests are not aborted. If req[k] drops mid-burst, the burst still completes and done still pulses.
- A requester that keeps req high after done is treated as a new request. It only wins again if no other requester is asserting req.
- burst_len changes after the grant has no effect on the current burst.
- busy = grant active OR state==GAP.

## Timing
- Let edge t be the first edge at which IDLE sees req≠0.
- At edge t: grant[k]=1, busy=1, sample_valid=1, sample_index=0.
- At edge t+i (i<len): sample_index=i.
- At edge t+len: grant=0, sample_valid=0, done[k]=1, burst_count+1.
- At edge t+len+1: done=0; busy stays 1 for GAP_CYCLES cycles.
- IDLE is re-entered at edge t+len+GAP_CYCLES. The earliest next grant is at edge t+len+GAP_CYCLES+1.
- Consequence: there are exactly len sample_valid cycles per burst and never two grants active at once.
- Requests arriving during RUN or GAP wait; they are evaluated only in IDLE.
- Reset asserted mid-burst: at the next edge all outputs return to their reset values and no done pulse is issued. burst_count clears.
- burst_count wraps from 0xFFFFFFFF to 0 without a flag.

## Test plan
- Single request: req=0001, len=5, GAP_CYCLES=2 -> grant=0001 for 5 cycles; sample_index 0..4; done[0] pulses the next cycle; burst_count=1; next grant no earlier than 3 cycles after done.
- Round-robin: req=1111 held, all len=3 -> grants in order 0,1,2,3,0; each owner receives 3 strobes; done pulses in the same order.
- Clamp and zero length:
  - len=100 with MAX_LEN=64 -> exactly 64 strobes, last index 63.
  - len=0 -> grant for 1 cycle, no sample_valid, done the next cycle.
- Request drop and late change: req[2] drops and burst_len[2] changes after the grant, len=8 -> all 8 strobes still issued; done[2] pulses; the new len is ignored.
- Reset mid-burst: assert reset at sample_index=3 of len=10 -> next edge all outputs are 0 and no done; after reset, req=0110 -> requester 1 is granted first.
- GAP_CYCLES=0 with back-to-back req=0011, len=2 -> grant[1] is asserted 1 cycle after done[0]; busy drops for exactly 1 cycle (the IDLE cycle).
